// File: rtl/dfc_tx_arb.sv
// dfc_tx_arb: round-robin N-channel transmitter for the delayed-flow-control link.
// Each registered link word carries the channel it came from.
module dfc_tx_arb #(
   parameter int width  = 8,
   parameter int inputs = 4,
   parameter int cnt_w  = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [inputs-1:0]           c_srdy,
   input  logic [inputs*width-1:0]     c_data,
   output logic [inputs-1:0]           c_drdy,
   output logic                        p_vld,
   output logic [width-1:0]            p_data,
   output logic [$clog2(inputs)-1:0]   p_ch,
   input  logic                        p_fc_n,
   output logic [cnt_w-1:0]            tx_cnt,
   output logic [cnt_w-1:0]            stall_cnt
);

   localparam int cw = $clog2(inputs);
   localparam logic [cw:0] NIN = (cw+1)'(inputs);

   logic              fc_q;
   logic [cw-1:0]     last_q, last_d;
   logic              vld_q, vld_d;
   logic [width-1:0]  data_q, data_d;
   logic [cw-1:0]     ch_q, ch_d;
   logic [cnt_w-1:0]  tx_q, tx_d;
   logic [cnt_w-1:0]  stall_q, stall_d;

   logic              hit;
   logic              gnt;
   logic [cw-1:0]     gsel;
   logic [cw:0]       idx;
   logic              any_req;

   assign any_req = |c_srdy;

   // Search last+1, last+2, ... wrapping at inputs, so no index >= inputs appears.
   always_comb begin
      hit  = 1'b0;
      gsel = last_q;
      idx  = '0;
      for (int k = 1; k <= inputs; k++) begin
         idx = {1'b0, last_q} + (cw+1)'(k);
         if (idx >= NIN) idx = idx - NIN;
         if (!hit && c_srdy[idx[cw-1:0]]) begin
            hit  = 1'b1;
            gsel = idx[cw-1:0];
         end
      end
      gnt = hit & fc_q;
   end

   always_comb begin
      c_drdy = '0;
      if (gnt) c_drdy[gsel] = 1'b1;
   end

   always_comb begin
      vld_d   = gnt;
      data_d  = data_q;
      ch_d    = ch_q;
      last_d  = last_q;
      tx_d    = tx_q;
      stall_d = stall_q;
      if (gnt) begin
         data_d = c_data[int'(gsel)*width +: width];
         ch_d   = gsel;
         last_d = gsel;
         if (tx_q != '1) tx_d = tx_q + cnt_w'(1);
      end
      if (!fc_q && any_req && stall_q != '1)
         stall_d = stall_q + cnt_w'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fc_q    <= 1'b0;
         last_q  <= cw'(inputs - 1);
         vld_q   <= 1'b0;
         data_q  <= '0;
         ch_q    <= '0;
         tx_q    <= '0;
         stall_q <= '0;
      end else begin
         fc_q    <= p_fc_n;
         last_q  <= last_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         tx_q    <= tx_d;
         stall_q <= stall_d;
      end
   end

   assign p_vld     = vld_q;
   assign p_data    = data_q;
   assign p_ch      = ch_q;
   assign tx_cnt    = tx_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_dfc_tx_arb.sv
// tb_dfc_tx_arb: random and directed stimulus against a behavioural
// round-robin model, with per-channel sequence checks and a receiver FIFO model.
module tb_dfc_tx_arb;

   localparam int W    = 8;
   localparam int N    = 4;
   localparam int CW   = 2;
   localparam int CNTW = 6;
   localparam int SAT  = (1 << CNTW) - 1;
   localparam int WORDS = 1000;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      c_srdy = '0;
   logic [N*W-1:0]    c_data = '0;
   logic [N-1:0]      c_drdy;
   logic              p_vld;
   logic [W-1:0]      p_data;
   logic [CW-1:0]     p_ch;
   logic              p_fc_n = 1'b1;
   logic [CNTW-1:0]   tx_cnt;
   logic [CNTW-1:0]   stall_cnt;

   always #5 clk = ~clk;

   dfc_tx_arb #(.width(W), .inputs(N), .cnt_w(CNTW)) dut (
      .clk(clk), .reset(reset),
      .c_srdy(c_srdy), .c_data(c_data), .c_drdy(c_drdy),
      .p_vld(p_vld), .p_data(p_data), .p_ch(p_ch),
      .p_fc_n(p_fc_n), .tx_cnt(tx_cnt), .stall_cnt(stall_cnt)
   );

   int nvec = 0;
   int nerr = 0;

   int seq[N];
   int rx_seq[N];
   bit link_on = 0;
   int fifo_cnt = 0;
   bit d1 = 0, d2 = 0;

   bit m_fc;
   int m_last, m_ch, m_tx, m_stall;
   bit m_vld;
   logic [W-1:0] m_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int last);
      int i;
      for (int k = 1; k <= N; k++) begin
         i = (last + k) % N;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic mreset();
      m_fc = 0; m_last = N - 1; m_vld = 0; m_data = '0;
      m_ch = 0; m_tx = 0; m_stall = 0;
   endtask

   // One compare process: check outputs, then advance the model over the next edge.
   always @(negedge clk) begin
      int g;
      logic [N-1:0] exp_drdy;
      if (!reset) begin
         mreset();
      end
      chk("p_vld", p_vld, m_vld);
      chk("p_ch", p_ch, m_ch);
      chk("p_data", p_data, m_data);
      chk("tx_cnt", tx_cnt, m_tx);
      chk("stall_cnt", stall_cnt, m_stall);
      if (reset && p_vld) begin
         chk("rx_order", p_data, rx_seq[p_ch] & 8'hff);
         rx_seq[p_ch]++;
      end
      g = (m_fc && c_srdy != 0) ? pick(c_srdy, m_last) : -1;
      exp_drdy = '0;
      if (g >= 0) exp_drdy[g] = 1'b1;
      chk("c_drdy", c_drdy, exp_drdy);
      if (reset) begin
         if (!m_fc && c_srdy != 0 && m_stall < SAT) m_stall++;
         if (g >= 0) begin
            m_vld = 1; m_data = c_data[g*W +: W]; m_ch = g; m_last = g;
            if (m_tx < SAT) m_tx++;
         end else begin
            m_vld = 0;
         end
         m_fc = p_fc_n;
      end
   end

   task automatic step(input logic [N-1:0] srdy, input logic fcn);
      logic [N-1:0] acc;
      @(negedge clk);
      acc = c_drdy & c_srdy;
      if (link_on) begin
         if (d2) fifo_cnt++;
         d2 = d1;
         d1 = p_vld;
         nvec++;
         if (fifo_cnt > 8) begin
            nerr++;
            $display("FAIL rx_overflow: got %0d want <=8", fifo_cnt);
         end
         if (fifo_cnt > 0 && $urandom_range(2) != 0) fifo_cnt--;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
      c_srdy = srdy;
      p_fc_n = fcn;
      for (int i = 0; i < N; i++) c_data[i*W +: W] = seq[i][W-1:0];
   endtask

   initial begin
      int exp_v[9];
      int exp_c[9];
      int cyc;
      bit done;
      logic [31:0] r;
      exp_v = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
      exp_c = '{2, 3, 0, 0, 0, 0, 0, 0, 1};
      for (int i = 0; i < N; i++) begin seq[i] = 0; rx_seq[i] = 0; end

      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld", p_vld, 0);
      chk("rst_tx", tx_cnt, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_drdy", c_drdy, 0);
      reset = 1'b1;

      // Single channel, back to back
      step(4'b0100, 1);
      for (int k = 0; k < 20; k++) begin
         step(k == 19 ? 4'b0000 : 4'b0100, 1);
         chk("single_vld", p_vld, 1);
         chk("single_ch", p_ch, 2);
         chk("single_data", p_data, k);
      end
      step(4'b0000, 1);
      chk("single_tx", tx_cnt, 20);
      chk("single_idle", p_vld, 0);

      // All ready: 0,1,2,3,0,1,2,3 after a ch3 word
      step(4'b1000, 1);
      step(4'b1111, 1);
      chk("all_pre", p_ch, 3);
      for (int k = 0; k < 8; k++) begin
         step(k == 7 ? 4'b0000 : 4'b1111, 1);
         chk("all_vld", p_vld, 1);
         chk("all_ch", p_ch, k % 4);
      end

      // Sparse 1001 starting with last=0
      step(4'b0001, 1);
      step(4'b1001, 1);
      chk("sparse_pre", p_ch, 0);
      for (int k = 0; k < 4; k++) begin
         step(k == 3 ? 4'b0000 : 4'b1001, 1);
         chk("sparse_ch", p_ch, (k % 2 == 0) ? 3 : 0);
      end
      step(4'b0000, 1);

      // Flow control drop for 5 cycles
      step(4'b1111, 1);
      step(4'b1111, 1);
      chk("fc_pre", p_ch, 1);
      chk("fc_stall0", stall_cnt, 0);
      for (int i = 0; i < 9; i++) begin
         step(4'b1111, (i <= 4) ? 1'b0 : 1'b1);
         chk("fc_vld", p_vld, exp_v[i]);
         if (exp_v[i] != 0) chk("fc_ch", p_ch, exp_c[i]);
      end
      chk("fc_stall", stall_cnt, 5);

      // Reset mid-stream
      chk("mid_vld_pre", p_vld, 1);
      reset = 1'b0;
      c_srdy = 4'b0010;
      #1;
      chk("mid_vld", p_vld, 0);
      chk("mid_ch", p_ch, 0);
      chk("mid_tx", tx_cnt, 0);
      chk("mid_stall", stall_cnt, 0);
      for (int i = 0; i < N; i++) rx_seq[i] = seq[i];
      step(4'b0010, 1);
      step(4'b0010, 1);
      reset = 1'b1;
      step(4'b0010, 1);
      chk("rel_vld1", p_vld, 0);
      step(4'b0000, 1);
      chk("rel_vld2", p_vld, 1);
      chk("rel_ch", p_ch, 1);
      step(4'b0000, 1);

      // Random traffic through a modelled 2-stage link and receiver FIFO
      link_on = 1;
      cyc = 0;
      done = 0;
      while (!done && cyc < 60000) begin
         r = $urandom;
         for (int i = 0; i < N; i++) if (seq[i] >= WORDS) r[i] = 1'b0;
         step(r[N-1:0], fifo_cnt <= 1);
         cyc++;
         done = 1;
         for (int i = 0; i < N; i++) if (seq[i] < WORDS) done = 0;
      end
      nvec++;
      if (!done) begin
         nerr++;
         $display("FAIL rand_timeout: got %0d cycles want done", cyc);
      end
      repeat (6) step(4'b0000, 1);
      link_on = 0;
      for (int i = 0; i < N; i++) chk("rand_count", rx_seq[i], seq[i]);
      chk("tx_sat", tx_cnt, SAT);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
